// File: rtl/slave_read_master.sv
// -----------------------------------------------------------------------------
// slave_read_master
//
// Bus-master sequencer for the slave readout card. It performs burst reads of
// N consecutive addresses starting from a programmable base address. Each word
// uses a four-phase handshake: present the address, raise CARD_SEL, wait for
// SACK_N low, capture SDO, drop CARD_SEL, then wait for SACK_N high.
// Every captured word is presented with its address as a one-cycle RD_VALID
// pulse.
//
// Optional feature (macro SRM_TIMEOUT_EN):
//   When defined, a wait counter aborts the burst if SACK_N does not change
//   within TIMEOUT_CYCLES cycles in REQ or REL. An aborted burst drops
//   CARD_SEL, sets the sticky ERR flag and pulses DONE. When undefined, there
//   is no counter, the handshake waits indefinitely and ERR is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  handshake wait limit (exists only with SRM_TIMEOUT_EN)
//   SETUP_CYCLES    cycles AI is held before CARD_SEL rises (1..15)
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-high reset
//   START      one-cycle burst start pulse, ignored while BUSY
//   BASE_ADDR  first address of the burst (sampled on START)
//   COUNT      words to read, 1..1024, 0 means 1024 (sampled on START)
//   SACK_N     slave acknowledge, active low
//   SDO        slave read data
//   CARD_SEL   slave select, active high
//   AI         slave address
//   WR_IN_N    write strobe, active low; constant 1 (read-only master)
//   RD_DATA    captured data word
//   RD_ADDR    address of RD_DATA
//   RD_VALID   one-cycle pulse, RD_DATA/RD_ADDR valid
//   BUSY       burst in progress
//   DONE       one-cycle pulse at burst end (normal or aborted)
//   ERR        sticky timeout abort flag, cleared by the next accepted START
// -----------------------------------------------------------------------------
module slave_read_master #(
`ifdef SRM_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255,
`endif
  parameter int SETUP_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [9:0]  BASE_ADDR,
  input  logic [10:0] COUNT,
  input  logic        SACK_N,
  input  logic [31:0] SDO,
  output logic        CARD_SEL,
  output logic [9:0]  AI,
  output logic        WR_IN_N,
  output logic [31:0] RD_DATA,
  output logic [9:0]  RD_ADDR,
  output logic        RD_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    CAPT,
    REL,
    DONE_S
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  state_t      state;
  logic        sack_q;     // SACK_N after one sample flop
  logic [3:0]  setup_cnt;
  logic [10:0] remaining;  // words still to capture, 1..1024
  logic        abort;      // handshake timed out this cycle

  assign WR_IN_N = 1'b1;

`ifdef SRM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  // Any state other than REQ/REL holds the counter at zero, so it is cleared
  // on every entry to REQ (from SETUP) and to REL (from CAPT).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt <= '0;
    end else if (state == REQ || state == REL) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Abort only when the awaited ack edge has not arrived; an ack sampled in
  // the final cycle still wins.
  assign abort = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) &&
                 ((state == REQ && sack_q) || (state == REL && !sack_q));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (state == IDLE && START) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign abort = 1'b0;
  assign ERR   = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in the block.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      sack_q    <= 1'b1;  // idle level of the active-low ack
      setup_cnt <= '0;
      remaining <= '0;
      CARD_SEL  <= 1'b0;
      AI        <= '0;
      RD_DATA   <= '0;
      RD_ADDR   <= '0;
      RD_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      sack_q   <= SACK_N;
      RD_VALID <= 1'b0;
      DONE     <= 1'b0;

      case (state)
        IDLE: begin
          if (START) begin
            AI        <= BASE_ADDR;
            remaining <= (COUNT == 11'd0) ? 11'd1024 : COUNT;
            BUSY      <= 1'b1;
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            setup_cnt <= '0;
            CARD_SEL  <= 1'b1;
            state     <= REQ;
          end else begin
            setup_cnt <= setup_cnt + 4'd1;
          end
        end

        // An ack that is already low here is legal: REL has already seen it
        // high, so this low belongs to the current request.
        REQ: begin
          if (!sack_q) begin
            state <= CAPT;
          end else if (abort) begin
            CARD_SEL <= 1'b0;
            state    <= DONE_S;
          end
        end

        CAPT: begin
          RD_DATA   <= SDO;
          RD_ADDR   <= AI;
          RD_VALID  <= 1'b1;
          CARD_SEL  <= 1'b0;
          remaining <= remaining - 11'd1;
          state     <= REL;
        end

        // CARD_SEL may only rise again after the ack is seen released, and AI
        // advances only here so it is stable across the whole handshake.
        REL: begin
          if (sack_q) begin
            if (remaining == 11'd0) begin
              state <= DONE_S;
            end else begin
              AI    <= AI + 10'd1;
              state <= SETUP;
            end
          end else if (abort) begin
            state <= DONE_S;
          end
        end

        DONE_S: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_read_master.sv
// -----------------------------------------------------------------------------
// tb_slave_read_master
//
// Self-checking bench for slave_read_master. A behavioural slave answers the
// four-phase handshake from a random memory image. Each burst pushes its
// expected (address, data) words into a queue, and a monitor pops and compares
// them on every RD_VALID. The monitor also checks the handshake ordering rules
// and the stability of AI. Define SRM_TIMEOUT_EN to add the abort scenario.
// -----------------------------------------------------------------------------
module tb_slave_read_master;

  localparam int TO_CYCLES = 255;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [9:0]  BASE_ADDR;
  logic [10:0] COUNT;
  logic        SACK_N;
  logic [31:0] SDO;
  logic        CARD_SEL;
  logic [9:0]  AI;
  logic        WR_IN_N;
  logic [31:0] RD_DATA;
  logic [9:0]  RD_ADDR;
  logic        RD_VALID;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  always #5 CLK = ~CLK;

  slave_read_master dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .COUNT     (COUNT),
    .SACK_N    (SACK_N),
    .SDO       (SDO),
    .CARD_SEL  (CARD_SEL),
    .AI        (AI),
    .WR_IN_N   (WR_IN_N),
    .RD_DATA   (RD_DATA),
    .RD_ADDR   (RD_ADDR),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] mem [1024];

  int n_checks   = 0;
  int n_errors   = 0;
  int done_count = 0;
  int exp_dones  = 0;
  int rv_count   = 0;
  int cs_run     = 0;
  int last_run   = 0;

  // Slave behaviour knobs.
  int ack_d    = 1;
  int rel_d    = 1;
  bit rand_dly = 1'b0;
  bit no_ack   = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave: acks ack_d cycles after seeing CARD_SEL, releases
  // rel_d cycles after CARD_SEL drops. Drives just after the rising edge.
  initial begin : slave
    int phase;
    int cnt;
    phase  = 0;
    cnt    = 0;
    SACK_N = 1'b1;
    SDO    = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (RESET) begin
        SACK_N = 1'b1;
        phase  = 0;
        cnt    = 0;
      end else if (phase == 0) begin
        if (CARD_SEL && !no_ack) begin
          if (cnt >= ack_d) begin
            SACK_N = 1'b0;
            SDO    = mem[AI];
            phase  = 1;
            cnt    = 0;
          end else begin
            cnt++;
          end
        end
      end else if (!CARD_SEL) begin
        if (cnt >= rel_d) begin
          SACK_N = 1'b1;
          SDO    = $urandom;
          phase  = 0;
          cnt    = 0;
          if (rand_dly) begin
            ack_d = $urandom_range(0, 4);
            rel_d = $urandom_range(0, 4);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: scoreboard pops, DONE counting, four-phase and AI-stability rules.
  initial begin : monitor
    logic       prev_cs;
    logic [9:0] prev_ai;
    bit         released;
    word_t      w;
    prev_cs  = 1'b0;
    prev_ai  = '0;
    released = 1'b1;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev_cs  = 1'b0;
        prev_ai  = AI;
        released = 1'b1;
        cs_run   = 0;
      end else begin
        if (RD_VALID) begin
          rv_count++;
          check("wr_in_n_high", WR_IN_N, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rd_valid: got addr 0x%0h, expected no word",
                     RD_ADDR);
          end else begin
            w = exp_q.pop_front();
            check("rd_addr", RD_ADDR, w.addr);
            check("rd_data", RD_DATA, w.data);
          end
        end
        if (DONE) done_count++;
        if (CARD_SEL && !prev_cs) check("four_phase_release", released, 1);
        if (!CARD_SEL && prev_cs) begin
          released = 1'b0;
          last_run = cs_run;
        end
        if (!CARD_SEL && SACK_N) released = 1'b1;
        if (AI != prev_ai)
          check("ai_change_outside_handshake", {released, CARD_SEL, prev_cs}, 3'b100);
        cs_run  = CARD_SEL ? cs_run + 1 : 0;
        prev_cs = CARD_SEL;
        prev_ai = AI;
      end
    end
  end

  // Issue one burst, wait for DONE (bounded), then check the end-of-burst state.
  task automatic run_burst(input logic [9:0] base, input logic [10:0] cnt,
                           input bit poke, input logic exp_err);
    int    n;
    int    budget;
    bit    seen;
    word_t w;
    n      = (cnt == 11'd0) ? 1024 : int'(cnt);
    budget = n * 40 + 600;
    seen   = 1'b0;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w.addr = base + 10'(i);
        w.data = mem[w.addr];
        exp_q.push_back(w);
      end
    end
    @(negedge CLK);
    BASE_ADDR = base;
    COUNT     = cnt;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", BUSY, 1);
    check("err_cleared_by_start", ERR, 0);
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge CLK);
      if (poke && c == 8) begin
        BASE_ADDR = ~base;
        COUNT     = 11'd3;
        START     = 1'b1;
      end else begin
        START = 1'b0;
      end
      #1;
      if (DONE) seen = 1'b1;
    end
    START = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no DONE, expected DONE within %0d cycles", budget);
      exp_q.delete();
    end
    exp_dones++;
    check("busy_at_done", BUSY, 0);
    check("words_outstanding", exp_q.size(), 0);
    check("err_at_done", ERR, exp_err);
    @(negedge CLK);
    #1;
    check("done_one_cycle", DONE, 0);
    check("done_count", done_count, exp_dones);
  endtask

  initial begin : stim
    int         rv0;
    bit         hit;
    logic [9:0] b;
    RESET     = 1'b1;
    START     = 1'b0;
    BASE_ADDR = '0;
    COUNT     = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    repeat (3) @(negedge CLK);
    check("rst_card_sel", CARD_SEL, 0);
    check("rst_ai", AI, 0);
    check("rst_wr_in_n", WR_IN_N, 1);
    check("rst_rd_data", RD_DATA, 0);
    check("rst_rd_addr", RD_ADDR, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Single read.
    mem[10'h045] = 32'hDEAD_BEEF;
    ack_d = 3;
    rel_d = 1;
    run_burst(10'h045, 11'd1, 1'b0, 1'b0);

    // Burst across the address wrap, data = {22'h0, addr}.
    for (int i = 0; i < 4; i++) begin
      b      = 10'h3FE + 10'(i);
      mem[b] = {22'h0, b};
    end
    run_burst(10'h3FE, 11'd4, 1'b0, 1'b0);

    // Slow release: ack held low 5 cycles after CARD_SEL drops.
    ack_d = 1;
    rel_d = 5;
    run_burst(10'($urandom), 11'd3, 1'b0, 1'b0);

    // Random bursts with random handshake delays.
    rand_dly = 1'b1;
    repeat (6) run_burst(10'($urandom), 11'($urandom_range(1, 20)), 1'b0, 1'b0);

    // START while busy must be ignored.
    run_burst(10'($urandom), 11'd6, 1'b1, 1'b0);
    rand_dly = 1'b0;

    // Reset during REQ of the third word of an 8-word burst.
    ack_d = 3;
    rel_d = 1;
    b     = 10'($urandom);
    for (int i = 0; i < 2; i++) exp_q.push_back({b + 10'(i), mem[b + 10'(i)]});
    rv0 = rv_count;
    hit = 1'b0;
    @(negedge CLK);
    BASE_ADDR = b;
    COUNT     = 11'd8;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge CLK);
      #1;
      if (rv_count == rv0 + 2 && CARD_SEL) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL reset_window_timeout: got %0d words, expected REQ of word 3",
               rv_count - rv0);
    end
    RESET = 1'b1;
    #1;
    check("mid_rst_card_sel", CARD_SEL, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_ai", AI, 0);
    check("mid_rst_rd_valid", RD_VALID, 0);
    check("mid_rst_rd_data", RD_DATA, 0);
    check("mid_rst_done", DONE, 0);
    check("mid_rst_words_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("mid_rst_no_done", done_count, exp_dones);
    run_burst(10'($urandom), 11'd5, 1'b0, 1'b0);

    // COUNT=0 means 1024 words from address 0.
    ack_d = 0;
    rel_d = 0;
    run_burst(10'h000, 11'd0, 1'b0, 1'b0);
    check("full_burst_last_addr", RD_ADDR, 10'h3FF);

`ifdef SRM_TIMEOUT_EN
    // Slave never acks: abort after TO_CYCLES cycles of CARD_SEL.
    no_ack = 1'b1;
    run_burst(10'($urandom), 11'd3, 1'b0, 1'b1);
    check("timeout_card_sel_cycles", last_run, TO_CYCLES);
    no_ack = 1'b0;
    ack_d  = 1;
    rel_d  = 1;
    run_burst(10'($urandom), 11'd2, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
